regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Multi-cycle instruction sequencer that drives the 8×16-bit register file from the controller side. It accepts one 16-bit instruction at a time over a valid/ready handshake and issues read addresses on the register-file read ports. It captures the returned operands, computes the result through an internal ALU/shifter, and issues the single write-back. It also maintains the Z/N/V status flags for later branch logic.

## Interface
- No parameters; all widths are fixed: 16-bit data, 3-bit register index.
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge
- `instr`  in  16  instruction word, sampled when `instr_valid && instr_ready`
- `instr_valid`  in  1  instruction present
- `instr_ready`  out  1  high only in WAIT
- `reg_a`  out  3  register-file read port A index (Rn)
- `reg_b`  out  3  register-file read port B index (Rm)
- `out_a`  in  16  register-file read data A (combinational from `reg_a`)
- `out_b`  in  16  register-file read data B (combinational from `reg_b`)
- `reg_w`  out  3  write index
- `write`  out  1  write enable, one-cycle pulse
- `data_out`  out  16  write data to register-file `data_in`
- `flags`  out  3  {Z,N,V}
- `done`  out  1  one-cycle pulse in the final cycle of each instruction
- `err`  out  1  high with `done` when the instruction is illegal

## Operation
- Fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- 110/10 MOV Rn,#imm8: Rn = sign-extended imm8.
- 110/00 MOV Rd,Rm: Rd = sh(Rm).
- 101/00 ADD: Rd = Rn + sh(Rm), 16-bit wrap.
- 101/01 CMP: Rn − sh(Rm); updates flags only, no write.
- 101/10 AND: Rd = Rn & sh(Rm).
- 101/11 MVN: Rd = ~sh(Rm).
- Any other opcode/op is illegal: no write, flags unchanged, `err`=1.
- sh: 00 pass; 01 LSL 1; 10 LSR 1 (MSB←0); 11 ASR 1 (MSB kept).
- Flags are updated only by CMP. Z = (diff==0); N = diff[15]; V = signed overflow of the subtraction (operand signs differ and result sign ≠ Rn sign).
- FSM states: WAIT, DECODE, READ, EXEC, WB.
- Transitions: WAIT→DECODE on accept. From DECODE: MOV-imm→WB; illegal→WAIT; else→READ. READ→EXEC. From EXEC: CMP→WAIT; else→WB. WB→WAIT.
- The instruction is latched into an internal IR at accept. `instr` is ignored outside WAIT.

## Timing
- Cycle A is the accept cycle.
- Register op: DECODE A+1, READ A+2, EXEC A+3, WB A+4. Operands are registered at the end of A+2; result and flags at the end of A+3. `write`=1 and `done`=1 in A+4.
- MOV imm: WB at A+2.
- CMP: `done` at A+3; new flags visible from A+4.
- Illegal: `done`=`err`=1 at A+1.
- `instr_ready` returns in the cycle after `done`. Back-to-back accept is possible then, and a following instruction always reads the just-written value.
- `reg_a`/`reg_b` hold Rn/Rm from DECODE through EXEC; `reg_w`/`data_out` are stable throughout WB.
- Reset values: state WAIT; `flags`=000; `write`, `done`, `err`=0; `reg_a`, `reg_b`, `reg_w`=0; `data_out`=0x0000; `instr_ready`=1 from the cycle after reset deasserts.
- Reset in any state aborts the instruction: no write is issued, and flags are not updated.

## Structure
- Shared package `regfile_ctrl_pkg` holds: opcode/op localparams, the shift-code enum, the state enum, and field-position constants.
- One combinational sub-module `ctrl_alu` holds the shifter, ADD/SUB/AND/NOT and flag generation. All sequencing lives in `regfile_ctrl`.

## Test plan
- 0xD007 (MOV R0,#7) → `write`=1, `reg_w`=0, `data_out`=0x0007 at A+2; `done` same cycle.
- 0xD1FF (MOV R1,#−1) → `data_out`=0xFFFF, `reg_w`=1.
- With R0=7, R1=0xFFFF: 0xA041 (ADD R2,R0,R1) → `reg_a`=0, `reg_b`=1 at A+2; `write` with 0x0006 to R2 at A+4. Repeat with sh=01 → 0x7+0xFFFE = 0x0005.
- 0xA800 (CMP R0,R0) → no `write`; `done` at A+3; `flags`=100. With Rn=0x7FFF, Rm=0xFFFF → `flags`=011.
- 0xE000 (illegal) → `done`=`err`=1 at A+1; no `write`; flags unchanged; `instr_ready` high at A+2.
- Assert `reset` at A+3 of an ADD → no `write` ever; WAIT and all outputs at reset values the next cycle; the next instruction executes normally.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl shared definitions: opcodes, field positions,
// shift codes, sequencer states and ALU operation select.
package regfile_ctrl_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

  typedef enum logic [1:0] {
    SH_PASS,
    SH_LSL,
    SH_LSR,
    SH_ASR
  } sh_e;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  typedef enum logic [2:0] {
    ALU_MOV,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_MVN
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Instruction handshake plus register-file port bundle.
// slave: the sequencer; master: the host and register file.
interface regfile_ctrl_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  reg_a;
  logic [2:0]  reg_b;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [2:0]  reg_w;
  logic        write;
  logic [15:0] data_out;
  logic [2:0]  flags;
  logic        done;
  logic        err;

  modport slave (
    input  instr, instr_valid, out_a, out_b,
    output instr_ready, reg_a, reg_b, reg_w,
    output write, data_out, flags, done, err
  );

  modport master (
    output instr, instr_valid, out_a, out_b,
    input  instr_ready, reg_a, reg_b, reg_w,
    input  write, data_out, flags, done, err
  );
endinterface

// File: rtl/ctrl_alu.sv
// Combinational shifter, ALU and compare-flag generator
// for the register-file sequencer.
module ctrl_alu
  import regfile_ctrl_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  sh_e         sh,
  input  alu_op_e     op,
  output logic [15:0] y,
  output flags_t      f
);

  logic [15:0] bs;
  logic [15:0] diff;

  always_comb begin
    bs = b;
    unique case (sh)
      SH_PASS: bs = b;
      SH_LSL:  bs = {b[14:0], 1'b0};
      SH_LSR:  bs = {1'b0, b[15:1]};
      SH_ASR:  bs = {b[15], b[15:1]};
      default: bs = b;
    endcase
  end

  assign diff = a - bs;

  always_comb begin
    y = bs;
    unique case (op)
      ALU_MOV: y = bs;
      ALU_ADD: y = a + bs;
      ALU_SUB: y = diff;
      ALU_AND: y = a & bs;
      ALU_MVN: y = ~bs;
      default: y = bs;
    endcase
  end

  // overflow: operand signs differ and result sign left a's sign
  always_comb begin
    f.z = (diff == 16'h0000);
    f.n = diff[15];
    f.v = (a[15] ^ bs[15]) & (diff[15] ^ a[15]);
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Multi-cycle instruction sequencer driving an 8x16 register
// file: decode, operand read, execute, single write-back.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
(
  input logic           clk,
  input logic           reset,
  regfile_ctrl_if.slave bus
);

  state_e      state, nxt;
  logic [15:0] ir;
  logic [15:0] opa, opb;
  logic [15:0] dout;
  logic [2:0]  rw;
  flags_t      flg;

  logic [2:0]  opc;
  logic [1:0]  op;
  logic        is_movi, is_movr, is_alu;
  logic        is_cmp, illegal;
  alu_op_e     aop;
  logic [15:0] alu_y;
  flags_t      alu_f;

  assign opc     = ir[OPC_LSB +: 3];
  assign op      = ir[OP_LSB +: 2];
  assign is_movi = (opc == OPC_MOV) && (op == OP_MOVI);
  assign is_movr = (opc == OPC_MOV) && (op == OP_MOVR);
  assign is_alu  = (opc == OPC_ALU);
  assign is_cmp  = is_alu && (op == OP_CMP);
  assign illegal = !(is_movi || is_movr || is_alu);

  always_comb begin
    aop = ALU_MOV;
    unique case (1'b1)
      is_alu && (op == OP_ADD): aop = ALU_ADD;
      is_cmp:                   aop = ALU_SUB;
      is_alu && (op == OP_AND): aop = ALU_AND;
      is_alu && (op == OP_MVN): aop = ALU_MVN;
      default:                  aop = ALU_MOV;
    endcase
  end

  ctrl_alu u_alu (
    .a  (opa),
    .b  (opb),
    .sh (sh_e'(ir[SH_LSB +: 2])),
    .op (aop),
    .y  (alu_y),
    .f  (alu_f)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_WAIT:   if (bus.instr_valid) nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_movi: nxt = S_WB;
          illegal: nxt = S_WAIT;
          default: nxt = S_READ;
        endcase
      end
      S_READ:   nxt = S_EXEC;
      S_EXEC:   nxt = is_cmp ? S_WAIT : S_WB;
      S_WB:     nxt = S_WAIT;
      default:  nxt = S_WAIT;
    endcase
  end

  // reset clears everything, so an aborted op never writes or flags
  always_ff @(posedge clk) begin
    if (reset) begin
      ir   <= '0;
      opa  <= '0;
      opb  <= '0;
      dout <= '0;
      rw   <= '0;
      flg  <= '0;
    end else begin
      if (state == S_WAIT && bus.instr_valid)
        ir <= bus.instr;
      if (state == S_DECODE && is_movi) begin
        dout <= {{8{ir[7]}}, ir[7:0]};
        rw   <= ir[RN_LSB +: 3];
      end
      if (state == S_READ) begin
        opa <= bus.out_a;
        opb <= bus.out_b;
      end
      if (state == S_EXEC) begin
        if (is_cmp) begin
          flg <= alu_f;
        end else begin
          dout <= alu_y;
          rw   <= ir[RD_LSB +: 3];
        end
      end
    end
  end

  always_comb begin
    bus.instr_ready = (state == S_WAIT);
    bus.write       = (state == S_WB);
    bus.done        = (state == S_WB)
                   || (state == S_EXEC && is_cmp)
                   || (state == S_DECODE && illegal);
    bus.err         = (state == S_DECODE) && illegal;
    bus.reg_a       = ir[RN_LSB +: 3];
    bus.reg_b       = ir[RM_LSB +: 3];
    bus.reg_w       = rw;
    bus.data_out    = dout;
    bus.flags       = flg;
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl with a behavioural
// register file answering the read ports.
module tb_regfile_ctrl;

  typedef struct {
    logic [15:0] ins;
    int          lat;
    logic        wr;
    logic [2:0]  rw;
    logic [15:0] d;
    logic        er;
    logic [2:0]  fl;
    logic        chk;
    logic [2:0]  ra;
    logic [2:0]  rb;
  } exp_t;

  logic clk = 0;
  logic reset = 1;
  regfile_ctrl_if bus ();

  regfile_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rf [8];
  assign bus.out_a = rf[bus.reg_a];
  assign bus.out_b = rf[bus.reg_b];
  always @(posedge clk)
    if (bus.write) rf[bus.reg_w] <= bus.data_out;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  exp_t cur;
  bit active = 0;
  bit pend = 0;
  logic [2:0] pf;
  int cyc = 0;
  int acc = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", nm);
  endtask

  function automatic exp_t mk(logic [15:0] ins, int lat,
      logic wr, logic [2:0] rw, logic [15:0] d, logic er,
      logic [2:0] fl, logic chk = 0, logic [2:0] ra = 0,
      logic [2:0] rb = 0);
    exp_t e;
    e.ins = ins; e.lat = lat; e.wr = wr; e.rw = rw;
    e.d = d; e.er = er; e.fl = fl; e.chk = chk;
    e.ra = ra; e.rb = rb;
    return e;
  endfunction

  always @(negedge clk) begin
    int k;
    cyc++;
    if (reset) begin
      active = 0;
      pend = 0;
    end else begin
      if (pend) begin
        check("flags", bus.flags, pf);
        check("ready_after_done", bus.instr_ready, 1);
        pend = 0;
      end
      if (active) begin
        k = cyc - acc;
        if (cur.chk && k == 2) begin
          check("reg_a", bus.reg_a, cur.ra);
          check("reg_b", bus.reg_b, cur.rb);
        end
        if (bus.done) begin
          check("latency", k, cur.lat);
          check("err", bus.err, cur.er);
          check("write", bus.write, cur.wr);
          if (cur.wr) begin
            check("reg_w", bus.reg_w, cur.rw);
            check("data_out", bus.data_out, cur.d);
          end
          pf = cur.fl;
          pend = 1;
          active = 0;
        end else if (bus.write) begin
          fail_evt("write_without_done");
        end else if (k > 8) begin
          fail_evt("done_timeout");
          active = 0;
        end
      end else if (bus.done || bus.write) begin
        fail_evt("spurious_done_or_write");
      end
      if (bus.instr_valid && bus.instr_ready) begin
        if (q.size() == 0) begin
          fail_evt("unexpected_accept");
        end else begin
          cur = q.pop_front();
          active = 1;
          acc = cyc;
        end
      end
    end
  end

  task automatic issue(exp_t e);
    bit got = 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.instr = e.ins;
    bus.instr_valid = 1;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      got = bus.instr_ready;
    end
    if (!got) begin
      fail_evt("accept_timeout");
      void'(q.pop_back());
    end
    @(posedge clk);
    #1;
    bus.instr_valid = 0;
    bus.instr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = '0;
    bus.instr = '0;
    bus.instr_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_ready", bus.instr_ready, 1);
    check("rst_write", bus.write, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_regs", {bus.reg_a, bus.reg_b, bus.reg_w}, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_flags", bus.flags, 0);

    issue(mk(16'hD007, 2, 1, 0, 16'h0007, 0, 3'b000));
    issue(mk(16'hD1FF, 2, 1, 1, 16'hFFFF, 0, 3'b000));
    issue(mk(16'hA041, 4, 1, 2, 16'h0006, 0, 3'b000, 1, 0, 1));
    issue(mk(16'hA049, 4, 1, 2, 16'h0005, 0, 3'b000));
    issue(mk(16'hA800, 3, 0, 0, 16'h0000, 0, 3'b100));
    issue(mk(16'hE000, 1, 0, 0, 16'h0000, 1, 3'b100));
    issue(mk(16'hC071, 4, 1, 3, 16'h7FFF, 0, 3'b100));
    issue(mk(16'hAB01, 3, 0, 0, 16'h0000, 0, 3'b011));
    issue(mk(16'hB081, 4, 1, 4, 16'h0007, 0, 3'b011));
    issue(mk(16'hB8B8, 4, 1, 5, 16'hFFFC, 0, 3'b011));
    issue(mk(16'hC0D9, 4, 1, 6, 16'hFFFF, 0, 3'b011));
    issue(mk(16'hC800, 1, 0, 0, 16'h0000, 1, 3'b011));
    issue(mk(16'hD800, 1, 0, 0, 16'h0000, 1, 3'b011));
    issue(mk(16'hAA00, 3, 0, 0, 16'h0000, 0, 3'b010));

    // abort an ADD in EXEC; any done/write for it must fail
    issue(mk(16'hA041, 99, 0, 0, 16'h0000, 0, 3'b000));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("abort_ready", bus.instr_ready, 1);
    check("abort_write", bus.write, 0);
    check("abort_done", bus.done, 0);
    check("abort_regs", {bus.reg_a, bus.reg_b, bus.reg_w}, 0);
    check("abort_data", bus.data_out, 0);
    check("abort_flags", bus.flags, 0);
    check("abort_rf_r2", rf[2], 16'h0005);

    issue(mk(16'hD00A, 2, 1, 0, 16'h000A, 0, 3'b000));
    issue(mk(16'hA000, 4, 1, 0, 16'h0014, 0, 3'b000));

    for (int w = 0; w < 50; w++) begin
      if (q.size() == 0 && !active && !pend) break;
      @(negedge clk);
    end
    if (q.size() != 0 || active || pend)
      fail_evt("drain_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
